// File: rtl/ifns_rx_buffer_26.sv
// Receive buffer for the 26-wire IFNS bus: FIFO with valid/ready output and registered head.
// Optional adjacent-bit pattern checker and error counter enabled by IFNS_RX_PATTERN_CHECK_EN.
module ifns_rx_buffer_26 #(
  parameter int DEPTH = 4,
  parameter int CW    = 26
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CW:1]              codein,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [CW:1]              codeout,
  output logic                     code_err,
  output logic                     overflow,
  output logic [15:0]              err_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef IFNS_RX_PATTERN_CHECK_EN
  localparam int EW = CW + 1;
`else
  localparam int EW = CW;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] level_next;
  logic [EW-1:0] in_entry, head_next;
  logic          full, push, pop;

`ifdef IFNS_RX_PATTERN_CHECK_EN
  logic perr;

  // A centre bit that differs from both neighbours is exactly a 010 or 101 triple.
  always_comb begin
    perr = 1'b0;
    for (int i = 2; i <= CW - 1; i++)
      perr |= (codein[i] ^ codein[i-1]) & (codein[i] ^ codein[i+1]);
  end

  assign in_entry = {perr, codein};
`else
  assign in_entry = codein;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    full       = (level == LW'(DEPTH));
    pop        = out_valid && out_ready;
    push       = in_valid && (!full || pop);
    rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_next = level + LW'(push) - LW'(pop);
    // When nothing remains behind the departing head, the new head is the incoming word.
    head_next  = (level == LW'(pop)) ? in_entry : mem[rd_next];
  end

  // NOTE: storage array has no reset; pointers and level define which entries are meaningful.
  always_ff @(posedge clock) begin
    if (!rst && push) mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      codeout   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_next;
      level     <= level_next;
      out_valid <= (level_next != '0);
      if (level_next != '0) codeout <= head_next[CW-1:0];
      if (in_valid && !push) overflow <= 1'b1;
    end
  end

`ifdef IFNS_RX_PATTERN_CHECK_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      code_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (level_next != '0) code_err <= head_next[CW];
      if (push && perr && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign code_err = 1'b0;
  assign err_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_ifns_rx_buffer_26.sv
// Scoreboard bench for ifns_rx_buffer_26: expected entries queued on push, compared on pop.
module tb_ifns_rx_buffer_26;

  localparam int DEPTH = 4;
`ifdef IFNS_RX_PATTERN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clock, rst, in_valid, out_ready;
  logic [26:1] codein;
  logic        out_valid, code_err, overflow;
  logic [26:1] codeout;
  logic [15:0] err_cnt;
  logic [2:0]  level;

  ifns_rx_buffer_26 #(.DEPTH(DEPTH), .CW(26)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .codein(codein),
    .out_ready(out_ready), .out_valid(out_valid), .codeout(codeout),
    .code_err(code_err), .overflow(overflow), .err_cnt(err_cnt), .level(level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  logic [26:0] q[$];
  logic        m_ovf;
  logic [15:0] m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_perr(input logic [26:1] c);
    logic [2:0] t;
    for (int i = 2; i <= 25; i++) begin
      t = {c[i+1], c[i], c[i-1]};
      if (t == 3'b010 || t == 3'b101) return CHK_EN;
    end
    return 1'b0;
  endfunction

  task automatic check_status();
    logic [26:0] h;
    check("level", 32'(level), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    if (q.size() != 0) begin
      h = q[0];
      check("head_word", 32'(codeout), 32'(h[25:0]));
      check("head_err", 32'(code_err), 32'(h[26]));
    end
  endtask

  task automatic step(input logic v, input logic [26:1] c, input logic r);
    logic        do_pop, do_push, pe;
    logic [26:0] e;
    in_valid  = v;
    codein    = c;
    out_ready = r;
    pe        = exp_perr(c);
    do_pop    = (q.size() != 0) && r;
    do_push   = v && (q.size() < DEPTH || do_pop);
    if (do_pop) begin
      e = q.pop_front();
      check("pop_word", 32'(codeout), 32'(e[25:0]));
      check("pop_err", 32'(code_err), 32'(e[26]));
    end
    if (do_push) begin
      q.push_back({pe, c});
      if (pe && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end else if (v) begin
      m_ovf = 1'b1;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check_status();
  endtask

  task automatic do_reset(input logic v, input logic [26:1] c);
    rst       = 1'b1;
    in_valid  = v;
    codein    = c;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_err = 16'h0000;
    check_status();
    check("rst_codeout", 32'(codeout), 32'h0);
    check("rst_code_err", 32'(code_err), 32'h0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 26'h0, 1'b1);
  endtask

  initial begin
    logic [26:1] c;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; codein = '0;
    m_ovf = 1'b0; m_err = 16'h0;
    @(posedge clock);
    #1;
    do_reset(1'b1, 26'h1555555);

    // Streaming
    step(1'b1, 26'h0000000, 1'b1);
    step(1'b1, 26'h0000003, 1'b1);
    step(1'b1, 26'h3FFFFFF, 1'b1);
    drain(2);

    // Pattern detect
    step(1'b1, 26'h0000005, 1'b1);
    step(1'b1, 26'h0000002, 1'b1);
    step(1'b1, 26'h2000000, 1'b1);
    drain(2);
    check("err_cnt_two", 32'(err_cnt), CHK_EN ? 32'd2 : 32'd0);

    // Full and overflow: A..E with downstream stalled
    do_reset(1'b0, 26'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 26'h0A0A0A0 + 26'(i), 1'b0);
    check("full_level", 32'(level), 32'd4);
    check("full_ovf", 32'(overflow), 32'd1);
    drain(5);

    // Simultaneous push and pop while full
    do_reset(1'b0, 26'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 26'h1230000 + 26'(i), 1'b0);
    step(1'b1, 26'h00FFF00, 1'b1);
    check("pp_level", 32'(level), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);
    drain(5);

    // Reset mid-operation with a push in the reset cycle
    do_reset(1'b0, 26'h0);
    step(1'b1, 26'h0000005, 1'b0);
    step(1'b1, 26'h0000000, 1'b0);
    step(1'b1, 26'h3FFFFFF, 1'b0);
    do_reset(1'b1, 26'h0000003);
    step(1'b0, 26'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) != 0) c = 26'($urandom);
      else c = 26'h3FFFFFF >> $urandom_range(0, 25);
      step(1'($urandom_range(0, 3) != 0), c, 1'($urandom_range(0, 2) != 0));
    end
    drain(DEPTH + 1);

`ifdef IFNS_RX_PATTERN_CHECK_EN
    // Counter saturation from a preloaded value
    do_reset(1'b0, 26'h0);
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    m_err = 16'hFFFE;
    step(1'b1, 26'h0000005, 1'b1);
    step(1'b1, 26'h0000002, 1'b1);
    step(1'b1, 26'h0000005, 1'b1);
    drain(2);
    check("err_sat", 32'(err_cnt), 32'h0000FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
